// File: rtl/max7219_sequencer.sv
// max7219_sequencer
//   Produces the 16-bit command frames that bring up a MAX7219 LED driver
//   and keep its digit registers refreshed. The frames go to an external SPI
//   shifter through a valid/ready handshake.
//
//   After reset the block sends the initialisation frames: test off, scan
//   limit, no decode, intensity and normal operation. It then refreshes every
//   digit once and waits in IDLE. From IDLE it writes a new intensity when
//   in_intensity changes. It refreshes all digits again when a refresh has
//   been requested, either by in_update or by the optional period timer.
//
// Ports
//   clock        system clock
//   reset        asynchronous active-high reset
//   in_data      segment bytes; byte i goes to digit register i+1
//   in_update    single-cycle refresh request
//   in_intensity runtime intensity (0..15)
//   frame_data   frame {4'h0, addr[3:0], data[7:0]}
//   frame_valid  frame_data holds a frame waiting to be shifted
//   frame_ready  shifter accepts the frame on this edge
//   busy         sequencer is outside IDLE
//   init_done    initialisation frames have all been accepted
//
// state      | meaning
// -----------+-------------------------------------------------------------
// INIT       | send the five configuration frames, steps 0..4
// IDLE       | wait for an intensity change or a pending refresh
// INTENSITY  | send a single intensity frame carrying in_intensity
// REFRESH    | send the digit frames 1..DIGITS from the in_data snapshot

module max7219_sequencer #(
  parameter int         DIGITS         = 8,
  parameter logic [3:0] INTENSITY_INIT = 4'h8,
  parameter int         REFRESH_PERIOD = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [8*DIGITS-1:0]   in_data,
  input  logic                  in_update,
  input  logic [3:0]            in_intensity,
  output logic [15:0]           frame_data,
  output logic                  frame_valid,
  input  logic                  frame_ready,
  output logic                  busy,
  output logic                  init_done
);

  typedef enum logic [1:0] {
    ST_INIT      = 2'd0,
    ST_IDLE      = 2'd1,
    ST_INTENSITY = 2'd2,
    ST_REFRESH   = 2'd3
  } state_t;

  localparam logic [2:0] INIT_LAST  = 3'd4;
  localparam logic [2:0] DIGIT_LAST = 3'(DIGITS - 1);
  localparam int         CNT_W      = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    (REFRESH_PERIOD > 0) ? CNT_W'(REFRESH_PERIOD - 1) : '0;

  state_t                state_q, state_d;
  logic [2:0]            step_q, step_d;
  logic                  valid_q, valid_d;
  logic [15:0]           data_q, data_d;
  logic                  init_done_q, init_done_d;
  logic                  pending_q, pending_d;
  logic [3:0]            last_int_q, last_int_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [8*DIGITS-1:0]   snap_q, snap_d;

  logic [63:0] snap_pad;
  logic [15:0] slot_frame;
  logic        period_wrap;
  logic        enter_refresh;
  logic        xfer;

  // Widen the snapshot to eight bytes. A 3-bit step then always selects a
  // byte inside the vector, whatever DIGITS is.
  assign snap_pad = 64'(snap_q);
  assign xfer     = valid_q & frame_ready;

  always_comb begin
    slot_frame = 16'h0000;
    case (state_q)
      ST_INIT: begin
        case (step_q)
          3'd0:    slot_frame = 16'h0F00;
          3'd1:    slot_frame = {8'h0B, 5'd0, DIGIT_LAST};
          3'd2:    slot_frame = 16'h0900;
          3'd3:    slot_frame = {8'h0A, 4'h0, INTENSITY_INIT};
          default: slot_frame = 16'h0C01;
        endcase
      end
      ST_INTENSITY: slot_frame = {8'h0A, 4'h0, in_intensity};
      ST_REFRESH:   slot_frame = {4'h0, {1'b0, step_q} + 4'd1,
                                  snap_pad[{step_q, 3'b000} +: 8]};
      default:      slot_frame = 16'h0000;
    endcase
  end

  // The period counter runs in every state. Its wrap only raises the
  // pending flag, so a wrap that falls during a refresh queues one more.
  always_comb begin
    cnt_d       = cnt_q;
    period_wrap = 1'b0;
    if (REFRESH_PERIOD > 0) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d       = '0;
        period_wrap = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    step_d        = step_q;
    valid_d       = valid_q;
    data_d        = data_q;
    init_done_d   = init_done_q;
    pending_d     = pending_q;
    last_int_d    = last_int_q;
    snap_d        = snap_q;
    enter_refresh = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (in_intensity != last_int_q) begin
          state_d = ST_INTENSITY;
          step_d  = 3'd0;
        end else if (pending_q) begin
          state_d       = ST_REFRESH;
          step_d        = 3'd0;
          enter_refresh = 1'b1;
        end
      end
      default: begin
        if (xfer) begin
          // Drop valid for one cycle. The next slot's frame is loaded on
          // the following edge.
          valid_d = 1'b0;
          case (state_q)
            ST_INIT: begin
              if (step_q == INIT_LAST) begin
                state_d       = ST_REFRESH;
                step_d        = 3'd0;
                init_done_d   = 1'b1;
                enter_refresh = 1'b1;
              end else begin
                step_d = step_q + 3'd1;
              end
            end
            ST_REFRESH: begin
              if (step_q == DIGIT_LAST) begin
                state_d = ST_IDLE;
                step_d  = 3'd0;
              end else begin
                step_d = step_q + 3'd1;
              end
            end
            default: begin
              state_d = ST_IDLE;
              step_d  = 3'd0;
            end
          endcase
        end else if (!valid_q) begin
          valid_d = 1'b1;
          data_d  = slot_frame;
          // Record the intensity that was actually sent. A change on
          // in_intensity while this frame is stalled is handled later from
          // IDLE.
          if (state_q == ST_INTENSITY) begin
            last_int_d = in_intensity;
          end
        end
      end
    endcase

    if (enter_refresh) begin
      snap_d    = in_data;
      pending_d = 1'b0;
    end
    // A new request in the same cycle wins over the clear on refresh entry.
    if (in_update || period_wrap) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_INIT;
      step_q      <= 3'd0;
      valid_q     <= 1'b0;
      data_q      <= 16'h0000;
      init_done_q <= 1'b0;
      pending_q   <= 1'b0;
      last_int_q  <= INTENSITY_INIT;
      cnt_q       <= '0;
      snap_q      <= '0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
      init_done_q <= init_done_d;
      pending_q   <= pending_d;
      last_int_q  <= last_int_d;
      cnt_q       <= cnt_d;
      snap_q      <= snap_d;
    end
  end

  assign frame_data  = data_q;
  assign frame_valid = valid_q;
  assign busy        = (state_q != ST_IDLE);
  assign init_done   = init_done_q;

endmodule

// File: doc/max7219_sequencer.md
MAX7219_SEQUENCER -- requirements
Module: max7219_sequencer

Interface
REQ-001 SHALL have parameter DIGITS, default 8, meaning number of digit registers refreshed (1..8).
REQ-002 SHALL have parameter INTENSITY_INIT, default 4'h8, meaning intensity written during initialisation.
REQ-003 SHALL have parameter REFRESH_PERIOD, default 0, meaning clock cycles between automatic refreshes (0 = disabled).
REQ-004 SHALL have one clock; reset is asynchronous and active-high.
REQ-005 SHALL have port clock, input, 1, the system clock.
REQ-006 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port in_data, input, 8*DIGITS, segment bytes (byte i drives digit register i+1).
REQ-008 SHALL have port in_update, input, 1, single-cycle refresh request.
REQ-009 SHALL have port in_intensity, input, 4, runtime intensity.
REQ-010 SHALL have port frame_data, output, 16, MAX7219 frame {4'h0, addr[3:0], data[7:0]}.
REQ-011 SHALL have port frame_valid, output, 1, frame_data holds a frame to shift.
REQ-012 SHALL have port frame_ready, input, 1, SPI shifter accepts the frame.
REQ-013 SHALL have port busy, output, 1, high outside IDLE.
REQ-014 SHALL have port init_done, output, 1, high once the init sequence has completed.

Function
REQ-015 SHALL transfer a frame only on a rising clock edge with frame_valid=1 and frame_ready=1.
REQ-016 SHALL hold frame_data stable and frame_valid high while frame_valid=1 and frame_ready=0.
REQ-017 SHALL implement states INIT, IDLE, INTENSITY, REFRESH.
REQ-018 SHALL, in INIT, emit in order: 16'h0F00 (test off), 16'h0B00|(DIGITS-1) (scan limit), 16'h0900 (no decode), 16'h0A00|INTENSITY_INIT, 16'h0C01 (normal operation); then set init_done=1 and enter REFRESH.
REQ-019 SHALL, on entry to REFRESH, snapshot in_data; digit frames then use the snapshot.
REQ-020 SHALL, in REFRESH, emit DIGITS frames, digit k (1..DIGITS) = {8'h0k, snapshot byte k-1}, ascending k, then return to IDLE.
REQ-021 SHALL, in IDLE, enter INTENSITY when in_intensity differs from the last written intensity; emit 16'h0A00|in_intensity and record it; then return to IDLE.
REQ-022 SHALL, in IDLE with no intensity change, enter REFRESH when a refresh is pending.
REQ-023 SHALL give an intensity change priority over a pending refresh when both exist in IDLE.
REQ-024 SHALL set the refresh-pending flag on in_update=1 in any state, including REFRESH, and clear it on REFRESH entry; a request arriving during REFRESH causes exactly one further refresh.
REQ-025 SHALL, when REFRESH_PERIOD>0, count cycles in every state, wrap at REFRESH_PERIOD-1, and set refresh-pending on wrap.
REQ-026 SHALL assert frame_valid the cycle after entering a frame-emitting slot; after a transfer, the next frame is valid on the following cycle (at most one idle cycle between frames).
REQ-027 SHALL ignore in_update and in_intensity for transmission until init_done=1 (pending flag still set).

Reset
REQ-028 SHALL, while reset=1, force state=INIT at step 0, frame_valid=0, frame_data=16'h0000, busy=1, init_done=0, pending=0, period counter=0, last intensity=INTENSITY_INIT.
REQ-029 SHALL, on reset asserted mid-frame or mid-sequence, abandon the frame and restart the full INIT sequence after release.
REQ-030 SHALL begin INIT emission on the first clock edge after reset deasserts.

Verification
REQ-031 SHALL verify: reset release, frame_ready=1 constantly, DIGITS=8 -> frames 0F00,0B07,0900,0A08,0C01 then 0100..0800 carrying in_data bytes; init_done rises after 0C01; busy falls after 08xx.
REQ-032 SHALL verify: frame_ready held 0 for 10 cycles on frame 0B07 -> frame_data/frame_valid unchanged for all 10 cycles; next frame 0900 after release.
REQ-033 SHALL verify: in_data=64'h0123456789ABCDEF, in_update pulse in IDLE, in_data changed the cycle after REFRESH entry -> frames 01EF,02CD,03AB,0489,0567,0645,0723,0801.
REQ-034 SHALL verify: in_update pulsed twice during REFRESH -> exactly one additional 8-frame refresh, then IDLE.
REQ-035 SHALL verify: in_intensity=4'h3 plus in_update in same IDLE cycle -> 0A03 emitted before digit frames; unchanged intensity afterwards emits no further 0Axx.
REQ-036 SHALL verify: reset pulsed during digit frame 04xx -> frame_valid=0 during reset, sequence restarts at 0F00, init_done=0 until 0C01 transfers.
